// File: rtl/ife_window_filter.sv
// 3x3 neighbourhood filter (mean/max/min/centre) over a raster image with zero padding.
// A sliding column window fetches three new pixels per output pixel.
module ife_window_filter #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned DW    = 8,
  localparam int unsigned AW   = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic [1:0]    sel,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_wr,
  output logic          wen
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned SW = DW + 4;
  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

  typedef enum logic [2:0] {StIdle, StPrefill, StFetch, StCalc, StWrite} state_e;

  state_e             state_q, state_d;
  logic [1:0]         ph_q, ph_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [1:0]         mode_q, mode_d;
  logic [2:0][DW-1:0] col_l_q, col_c_q, col_r_q;
  logic               rd_vld_q, rd_inr_q;
  logic [1:0]         rd_tap_q;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      data_q;

  logic               issue, row_ok, col_ok, shift;
  logic [YW-1:0]      row;
  logic [XW-1:0]      col;
  logic [DW-1:0]      tap;
  logic [2:0][DW-1:0] r_full;
  logic [8:0][DW-1:0] taps;
  logic [SW-1:0]      sum;
  logic [DW-1:0]      mx, mn, result;

  // FSM next state
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    case (state_q)
      StIdle: begin
        if (ready) begin
          mode_d  = sel;
          x_d     = '0;
          y_d     = '0;
          ph_d    = '0;
          state_d = StPrefill;
        end
      end
      StPrefill: begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd3) begin
          ph_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd2) begin
          ph_d    = '0;
          state_d = StCalc;
        end
      end
      StCalc: state_d = StWrite;
      StWrite: begin
        if (x_q == XLast) begin
          x_d = '0;
          if (y_q == YLast) begin
            state_d = StIdle;
          end else begin
            y_d     = y_q + YW'(1);
            state_d = StPrefill;
          end
        end else begin
          x_d     = x_q + XW'(1);
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read address: out-of-range rows/columns are clamped and flagged for masking
  always_comb begin
    issue  = (state_q == StPrefill && ph_q != 2'd3) || state_q == StFetch;
    row    = y_q;
    row_ok = 1'b1;
    case (ph_q)
      2'd0: begin
        if (y_q == '0) row_ok = 1'b0;
        else           row    = y_q - YW'(1);
      end
      2'd2: begin
        if (y_q == YLast) row_ok = 1'b0;
        else              row    = y_q + YW'(1);
      end
      default: ;
    endcase
    col    = '0;
    col_ok = 1'b1;
    if (state_q == StFetch) begin
      if (x_q == XLast) begin
        col    = XLast;
        col_ok = 1'b0;
      end else begin
        col = x_q + XW'(1);
      end
    end
    iaddr = issue ? AW'(row) * AW'(IMG_W) + AW'(col) : '0;
  end

  // Window with the in-flight tap merged in, and the selected reduction
  always_comb begin
    tap    = (rd_vld_q && rd_inr_q) ? idata : '0;
    r_full = col_r_q;
    if (rd_vld_q) r_full[rd_tap_q] = tap;
    taps   = {r_full, col_c_q, col_l_q};
    sum    = '0;
    mx     = '0;
    mn     = '1;
    for (int i = 0; i < 9; i++) begin
      sum = sum + SW'(taps[i]);
      if (taps[i] > mx) mx = taps[i];
      if (taps[i] < mn) mn = taps[i];
    end
    case (mode_q)
      2'd0:    result = DW'(sum / SW'(9));
      2'd1:    result = mx;
      2'd2:    result = mn;
      default: result = taps[4];
    endcase
  end

  assign shift = (state_q == StPrefill && ph_q == 2'd3) || state_q == StCalc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      ph_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= '0;
      col_l_q  <= '0;
      col_c_q  <= '0;
      col_r_q  <= '0;
      rd_vld_q <= 1'b0;
      rd_inr_q <= 1'b0;
      rd_tap_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      rd_vld_q <= issue;
      rd_inr_q <= row_ok && col_ok;
      rd_tap_q <= ph_q;
      col_r_q  <= r_full;
      // Row start: left pad columns are zero
      if (state_q != StPrefill && state_d == StPrefill) begin
        col_l_q <= '0;
        col_c_q <= '0;
      end else if (shift) begin
        col_l_q <= col_c_q;
        col_c_q <= r_full;
      end
      if (state_q == StCalc) begin
        addr_q <= AW'(y_q) * AW'(IMG_W) + AW'(x_q);
        data_q <= result;
      end
    end
  end

  assign busy    = (state_q != StIdle);
  assign wen     = (state_q == StWrite);
  assign addr    = addr_q;
  assign data_wr = data_q;

endmodule

// File: tb/tb_ife_window_filter.sv
// Randomised self-checking bench for ife_window_filter on an 8x4 image against a
// zero-padded 3x3 reference model.
module tb_ife_window_filter;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);
  localparam int BUSY_CYC = H * (4 + 5 * W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ready = 1'b0;
  logic [1:0]    sel = 2'd0;
  logic          busy, wen;
  logic [AW-1:0] iaddr, addr;
  logic [7:0]    idata, data_wr;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] img [N];
  logic [7:0] out_img [N];
  int job_sel = 0;
  int exp_addr = 0;
  int wr_cnt = 0;
  int last_wr = 0;
  logic busy_prev = 1'b0;

  ife_window_filter #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk(clk), .reset(rst_n), .ready(ready), .sel(sel), .busy(busy),
    .iaddr(iaddr), .idata(idata), .addr(addr), .data_wr(data_wr), .wen(wen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Image memory with one-cycle read latency; undriven data while idle
  always @(posedge clk) idata <= busy ? img[iaddr] : 8'bx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(int x, int y, int mode);
    int s = 0;
    int mx = 0;
    int mn = 255;
    int v;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          v = int'(img[(y + dy) * W + x + dx]);
        else
          v = 0;
        s += v;
        if (v > mx) mx = v;
        if (v < mn) mn = v;
      end
    end
    case (mode)
      0:       return s / 9;
      1:       return mx;
      2:       return mn;
      default: return int'(img[y * W + x]);
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        exp_addr = 0;
        wr_cnt   = 0;
      end
      if (wen) begin
        chk("wr_addr", 32'(addr), exp_addr);
        chk("wr_data", 32'(data_wr), model(exp_addr % W, exp_addr / W, job_sel));
        if (wr_cnt > 0) chk("wr_gap", cyc - last_wr, (exp_addr % W == 0) ? 9 : 5);
        if (exp_addr < N) out_img[exp_addr] = data_wr;
        last_wr = cyc;
        wr_cnt++;
        exp_addr++;
      end
      if (!busy && busy_prev) chk("wr_count", wr_cnt, N);
      busy_prev = busy;
    end
  end

  task automatic wait_done(output int n);
    bit done = 0;
    n = 1;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (busy) n++;
      else done = 1;
    end
  endtask

  task automatic run_job(input int mode, input bit toggle, input bit hold);
    int n;
    job_sel = mode;
    sel = 2'(mode);
    for (int i = 0; i < N; i++) out_img[i] = 8'bx;
    @(negedge clk);
    ready = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", 32'(busy), 1);
    if (!hold) ready = 1'b0;
    n = 1;
    for (int k = 0; k < 1000 && busy; k++) begin
      @(negedge clk);
      if (toggle) sel = 2'($urandom_range(3));
      if (busy) n++;
    end
    chk("busy_cycles", n, BUSY_CYC);
    sel = 2'(mode);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    #23;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_iaddr", 32'(iaddr), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", 32'(data_wr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Linear pattern, mean
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y * W + x] = 8'((x * 37 + y * 11) & 255);
    run_job(0, 0, 0);
    chk("pat_mean_00", 32'(out_img[0]), 10);
    chk("pat_mean_11", 32'(out_img[9]), 48);
    chk("pat_mean_73", 32'(out_img[31]), 62);
    run_job(1, 0, 0);
    chk("pat_max_00", 32'(out_img[0]), 48);

    // Constant 90, mean: corner/edge/interior
    for (int i = 0; i < N; i++) img[i] = 8'd90;
    run_job(0, 0, 0);
    chk("c90_corner", 32'(out_img[0]), 40);
    chk("c90_edge", 32'(out_img[1]), 60);
    chk("c90_inner", 32'(out_img[9]), 90);

    // Single spike at (5,2), max
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    img[2 * W + 5] = 8'd255;
    run_job(1, 0, 0);
    chk("spike_41", 32'(out_img[12]), 255);
    chk("spike_63", 32'(out_img[30]), 255);
    chk("spike_31", 32'(out_img[11]), 0);
    chk("spike_00", 32'(out_img[0]), 0);

    // Constant 200, min: border is pulled to zero
    for (int i = 0; i < N; i++) img[i] = 8'd200;
    run_job(2, 0, 0);
    chk("c200_inner", 32'(out_img[9]), 200);
    chk("c200_edge", 32'(out_img[1]), 0);

    // Random image, centre copy, sel toggled during the job
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    run_job(3, 1, 0);
    for (int i = 0; i < N; i += 7) chk("copy", 32'(out_img[i]), 32'(img[i]));

    // Random images and modes
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < N; i++) img[i] = 8'($urandom);
      run_job(int'($urandom_range(3)), 1, 0);
    end

    // ready held high: next job starts after one idle cycle
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    run_job(0, 0, 1);
    @(negedge clk);
    chk("b2b_restart", 32'(busy), 1);
    ready = 1'b0;
    wait_done(n);
    chk("b2b_cycles", n, BUSY_CYC);

    // Reset during a write cycle
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    job_sel = 0;
    sel = 2'd0;
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (wen && wr_cnt >= 7) break;
    end
    chk("mid_wen_seen", 32'(wen), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wen", 32'(wen), 0);
    chk("mid_rst_iaddr", 32'(iaddr), 0);
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_data", 32'(data_wr), 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_auto_restart", 32'(busy), 0);
    run_job(0, 0, 0);
    chk("post_rst_00", 32'(out_img[0]), model(0, 0, 0));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ife_window_filter.md
# ife_window_filter

Parametrised 3x3 neighbourhood filter engine, the next generation of the fixed 128x128 mean-only image filter engine (IFE). It reads a greyscale image from the host image port (`iaddr`/`idata`), applies one of four 3x3 window operations selected per job, and writes the result image, one byte per pixel, through the result-memory port (`addr`/`data_wr`/`wen`). Image size and pixel width are parameters. A sliding column window fetches only 3 new pixels per output pixel.

## Interface
- `IMG_W`, 128: image width in pixels, ≥2.
- `IMG_H`, 128: image height in pixels, ≥2.
- `DW`, 8: pixel width in bits.
- `AW`, clog2(IMG_W*IMG_H): address width, derived, not overridden.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ready` in 1: host job request, level.
- `sel` in 2: mode, latched at job start: 0 mean, 1 max, 2 min, 3 centre copy.
- `busy` out 1: job in progress.
- `iaddr` out AW: image read address, y*IMG_W+x.
- `idata` in DW: image pixel, valid the cycle after `iaddr` is presented.
- `addr` out AW: result write address, y*IMG_W+x.
- `data_wr` out DW: result pixel.
- `wen` out 1: result write strobe, 1 = write in that cycle.

## Operation
- States: IDLE, PREFILL, FETCH, CALC, WRITE.
- IDLE:
  - A rising edge with `ready`=1 latches `sel`, sets x=0 and y=0, raises `busy`, and enters PREFILL.
- PREFILL (row start):
  - Issues 3 addresses for column 0, rows y-1, y, y+1. Then 1 capture cycle. Total 4 cycles.
  - The window left column and centre column are cleared to 0 (left pad). Column 0 is loaded as the right column, then shifted into the centre.
- FETCH (3 cycles):
  - Issues column x+1, rows y-1, y, y+1.
  - `idata` is captured one cycle after each address.
- CALC (1 cycle):
  - Captures the last tap and shifts the window left.
  - Taps outside the image are forced to 0 (zero padding for all modes). The fetch cycles still occur; out-of-range addresses are clamped and their data is masked.
- WRITE (1 cycle):
  - `wen`=1, `addr`=y*IMG_W+x, `data_wr`=result.
  - Then x increments. At x=IMG_W-1, x returns to 0, y increments, and the engine goes to PREFILL. After the last pixel it goes to IDLE.
- Arithmetic:
  - Sum is DW+4 bits and must not overflow.
  - mean = floor(sum/9), exact for every sum up to 9*(2^DW-1).
  - max and min are taken over all 9 taps, padding zeros included.
  - Mode 3 outputs the centre tap.
- Write order is strict raster. Every pixel is written exactly once per job.
- `sel` changes while `busy`=1 are ignored.

## Timing
- Reset values: `busy`=0, `wen`=0, `iaddr`=0, `addr`=0, `data_wr`=0. State IDLE, all counters and window registers 0.
- Reset asserted mid-job: outputs take their reset values asynchronously and the job is abandoned. The next job needs a fresh `ready`.
- `busy` rises on the edge that samples `ready`=1 in IDLE. It falls on the edge after the final WRITE cycle.
- `busy` high time is exactly IMG_H*(4+5*IMG_W) cycles. For 128x128 this is 82432 cycles.
- `wen` is high for 1 cycle, every 5 cycles within a row. The gap between the last write of a row and the first write of the next row is 9 cycles.
- `ready` may stay high through the job. If `ready` is still 1 when the engine returns to IDLE, a new job starts on the next edge.
- `idata` is sampled only in the cycle after a FETCH or PREFILL address. `idata`=X at any other time must not propagate.

## Test plan
- 128x128 constant 90, sel=0 -> interior 90, non-corner border 60, corners 40. `busy` high 82432 cycles; 16384 `wen` pulses.
- 128x128 all 0 except pixel (5,5)=255, sel=1 -> 255 at x,y∈{4,5,6}, 0 elsewhere.
- 128x128 constant 200, sel=2 -> interior 200, all border pixels 0.
- Random 128x128, sel=3 -> output equals input bit-exact. Addresses strictly 0..16383 in order. `sel` toggled mid-job has no effect.
- IMG_W=8, IMG_H=4, DW=8, pixel=(x*37+y*11)&255, sel=0 -> matches the floor(sum/9) zero-pad model. `busy` high 176 cycles.
- 128x128 sel=0 with `reset` pulsed low at cycle 3000 -> `busy`/`wen` drop within that cycle. Restart with `ready` -> full image correct, 82432 cycles.
